// File: rtl/line_engine.sv
// line_engine: Bresenham line rasteriser feeding vga_adapter one pixel per clock.
// A rising edge on go captures (new_x, new_y) as the end point, the line is drawn
// from the stored origin to it, and the end point then becomes the next origin.
// Optional feature: define LINE_CLIP_EN to clamp captured end points to X_MAX/Y_MAX.
//
// Handshake: ready is high only in IDLE. A synchronised rising edge of go seen
// while ready is high is accepted on that cycle; edges seen while ready is low
// are dropped, so the user has to toggle go again.
module line_engine #(
   parameter int X_WIDTH = 9,
   parameter int Y_WIDTH = 8,
   parameter int X_MAX   = 319,
   parameter int Y_MAX   = 239
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               go,
   input  logic [X_WIDTH-1:0] new_x,
   input  logic [Y_WIDTH-1:0] new_y,
   output logic               ready,
   output logic               done,
   output logic [X_WIDTH-1:0] x,
   output logic [Y_WIDTH-1:0] y,
   output logic               plot
);

   // Internal arithmetic width: wide enough for any difference of two coordinates
   localparam int CW = 11;
   localparam logic signed [CW-1:0] STEP_POS = 1;
   localparam logic signed [CW-1:0] STEP_NEG = -1;

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW, S_DONE} state_t;

   state_t state;
   state_t state_nxt;

   logic go_meta, go_s, go_s_d, start;

   logic [X_WIDTH-1:0] cap_x, end_x, org_x;
   logic [Y_WIDTH-1:0] cap_y, end_y, org_y;

   logic signed [CW-1:0] ex, ey, ox, oy;
   logic signed [CW-1:0] dx, dy, sx, sy, err, cur_x, cur_y;
   logic signed [CW-1:0] dx_init, dy_init, err_nxt;
   logic signed [CW:0]   e2, dx_w, dy_w;
   logic                 x_fwd, y_fwd, step_x, step_y, at_end;

`ifdef LINE_CLIP_EN
   localparam logic [X_WIDTH-1:0] X_LIM = X_WIDTH'(X_MAX);
   localparam logic [Y_WIDTH-1:0] Y_LIM = Y_WIDTH'(Y_MAX);
   assign cap_x = (new_x > X_LIM) ? X_LIM : new_x;
   assign cap_y = (new_y > Y_LIM) ? Y_LIM : new_y;
`else
   // Raw capture: off-screen pixels are strobed and vga_adapter drops them
   assign cap_x = new_x;
   assign cap_y = new_y;
`endif

   // Coordinates are unsigned; zero-extend before treating them as signed
   assign ex = signed'(CW'(end_x));
   assign ey = signed'(CW'(end_y));
   assign ox = signed'(CW'(org_x));
   assign oy = signed'(CW'(org_y));

   assign x_fwd   = (ex >= ox);
   assign y_fwd   = (ey >= oy);
   assign dx_init = x_fwd ? (ex - ox) : (ox - ex);
   // dy is kept as the negative magnitude, as in the classic integer form
   assign dy_init = y_fwd ? (oy - ey) : (ey - oy);

   assign e2      = {err, 1'b0};
   assign dx_w    = (CW+1)'(dx);
   assign dy_w    = (CW+1)'(dy);
   assign step_x  = (e2 >= dy_w);
   assign step_y  = (e2 <= dx_w);
   assign err_nxt = err + (step_x ? dy : CW'(0)) + (step_y ? dx : CW'(0));
   assign at_end  = (cur_x == ex) && (cur_y == ey);

   assign start = go_s & ~go_s_d;
   assign x     = cur_x[X_WIDTH-1:0];
   assign y     = cur_y[Y_WIDTH-1:0];

   // Two-flop synchroniser plus edge-detect stage for the asynchronous go level
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         go_meta <= 1'b0;
         go_s    <= 1'b0;
         go_s_d  <= 1'b0;
      end else begin
         go_meta <= go;
         go_s    <= go_meta;
         go_s_d  <= go_s;
      end
   end

   // FSM state register
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nxt;
   end

   // FSM next state and state-decoded outputs
   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      plot      = 1'b0;
      done      = 1'b0;
      unique case (state)
         S_IDLE: begin
            ready = 1'b1;
            if (start) state_nxt = S_SETUP;
         end
         S_SETUP: state_nxt = S_DRAW;
         S_DRAW: begin
            plot = 1'b1;
            if (at_end) state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath: capture, line setup, per-pixel stepping and origin update
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         end_x <= '0;
         end_y <= '0;
         org_x <= '0;
         org_y <= '0;
         dx    <= '0;
         dy    <= '0;
         sx    <= '0;
         sy    <= '0;
         err   <= '0;
         cur_x <= '0;
         cur_y <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  end_x <= cap_x;
                  end_y <= cap_y;
               end
            end
            S_SETUP: begin
               dx    <= dx_init;
               dy    <= dy_init;
               sx    <= x_fwd ? STEP_POS : STEP_NEG;
               sy    <= y_fwd ? STEP_POS : STEP_NEG;
               err   <= dx_init + dy_init;
               cur_x <= ox;
               cur_y <= oy;
            end
            S_DRAW: begin
               if (!at_end) begin
                  err <= err_nxt;
                  if (step_x) cur_x <= cur_x + sx;
                  if (step_y) cur_y <= cur_y + sy;
               end
            end
            S_DONE: begin
               org_x <= end_x;
               org_y <= end_y;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_line_engine.sv
// tb_line_engine: directed table of end points with hand-computed pixel counts
// and end pixels, a pixel-by-pixel scoreboard fed by an integer Bresenham model,
// and hand-written sequences for go toggling, mid-line reset and go held
// through reset release.
module tb_line_engine;

   logic       clock;
   logic       resetn;
   logic       go;
   logic [8:0] new_x;
   logic [7:0] new_y;
   logic       ready;
   logic       done;
   logic [8:0] x;
   logic [7:0] y;
   logic       plot;

   int checks = 0;
   int errors = 0;
   logic [16:0] exp_q[$];
   int x_log[$];
   int y_log[$];
   int ox = 0;
   int oy = 0;

   typedef struct {
      int nx;
      int ny;
      int exp_n;
      int lx;
      int ly;
   } vec_t;

   vec_t tbl[8];

   line_engine #(
      .X_WIDTH(9),
      .Y_WIDTH(8),
      .X_MAX  (319),
      .Y_MAX  (239)
   ) dut (
      .clock (clock),
      .resetn(resetn),
      .go    (go),
      .new_x (new_x),
      .new_y (new_y),
      .ready (ready),
      .done  (done),
      .x     (x),
      .y     (y),
      .plot  (plot)
   );

   // Clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   function automatic int clip_x(input int v);
`ifdef LINE_CLIP_EN
      return (v > 319) ? 319 : v;
`else
      return v;
`endif
   endfunction

   function automatic int clip_y(input int v);
`ifdef LINE_CLIP_EN
      return (v > 239) ? 239 : v;
`else
      return v;
`endif
   endfunction

   // Reference rasteriser: pushes every expected pixel as {x, y}
   function automatic void model_line(input int x0, input int y0, input int x1, input int y1);
      int ddx, ddy, stx, sty, e, e2, cx, cy, guard;
      ddx = (x1 > x0) ? x1 - x0 : x0 - x1;
      ddy = -((y1 > y0) ? y1 - y0 : y0 - y1);
      stx = (x1 >= x0) ? 1 : -1;
      sty = (y1 >= y0) ? 1 : -1;
      e   = ddx + ddy;
      cx  = x0;
      cy  = y0;
      guard = 0;
      while (guard < 1000) begin
         exp_q.push_back({cx[8:0], cy[7:0]});
         if (cx == x1 && cy == y1) break;
         e2 = 2 * e;
         if (e2 >= ddy) begin e += ddy; cx += stx; end
         if (e2 <= ddx) begin e += ddx; cy += sty; end
         guard++;
      end
   endfunction

   // Present a point and raise go; returns once ready has dropped (go lowered)
   task automatic start_line(input int nx, input int ny);
      int cyc;
      @(negedge clock);
      new_x = nx[8:0];
      new_y = ny[7:0];
      go    = 1'b1;
      cyc   = 0;
      while (ready && cyc < 8) begin
         @(negedge clock);
         cyc++;
      end
      check("ready_fall_latency", cyc, 3);
      go = 1'b0;
   endtask

   // Follow a line until done, scoring each pixel; optionally toggle go and
   // change the point inputs mid-line starting at pixel toggle_at
   task automatic collect(input int toggle_at, output int n, output int lx, output int ly);
      int cyc;
      bit fin;
      logic [16:0] ev;
      n   = 0;
      lx  = -1;
      ly  = -1;
      cyc = 0;
      fin = 1'b0;
      x_log.delete();
      y_log.delete();
      while (!fin && cyc < 1000) begin
         @(negedge clock);
         cyc++;
         if (plot) begin
            check("ready_low_while_plot", 32'(ready), 0);
            ev = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1ffff;
            check("pixel_xy", 32'({x, y}), 32'(ev));
            n++;
            lx = int'(x);
            ly = int'(y);
            x_log.push_back(lx);
            y_log.push_back(ly);
            if (toggle_at > 0) begin
               if (n == toggle_at) begin
                  go    = 1'b1;
                  new_x = 9'd7;
                  new_y = 8'd7;
               end
               if (n == toggle_at + 5)  go = 1'b0;
               if (n == toggle_at + 10) go = 1'b1;
            end
         end
         if (done) begin
            fin = 1'b1;
            check("done_without_plot", 32'(plot), 0);
         end
      end
      check("done_seen", 32'(fin), 1);
      check("all_pixels_plotted", exp_q.size(), 0);
      exp_q.delete();
      @(negedge clock);
      check("ready_after_done", 32'(ready), 1);
      check("done_single_cycle", 32'(done), 0);
   endtask

   initial begin
      int n, lx, ly, ex, ey, quiet, cyc;
      int x_hand[9];
      x_hand = '{0, 1, 1, 2, 2, 3, 3, 4, 4};

      tbl[0] = '{nx: 10,  ny: 0,   exp_n: 11,  lx: 10,  ly: 0};
      tbl[1] = '{nx: 10,  ny: 0,   exp_n: 1,   lx: 10,  ly: 0};
      tbl[2] = '{nx: 0,   ny: 0,   exp_n: 11,  lx: 0,   ly: 0};
      tbl[3] = '{nx: 4,   ny: 8,   exp_n: 9,   lx: 4,   ly: 8};
      tbl[4] = '{nx: 319, ny: 239, exp_n: 316, lx: 319, ly: 239};
      tbl[5] = '{nx: 0,   ny: 0,   exp_n: 320, lx: 0,   ly: 0};
`ifdef LINE_CLIP_EN
      tbl[6] = '{nx: 400, ny: 250, exp_n: 320, lx: 319, ly: 239};
      tbl[7] = '{nx: 0,   ny: 0,   exp_n: 320, lx: 0,   ly: 0};
`else
      tbl[6] = '{nx: 400, ny: 250, exp_n: 401, lx: 400, ly: 250};
      tbl[7] = '{nx: 0,   ny: 0,   exp_n: 401, lx: 0,   ly: 0};
`endif

      // Reset
      resetn = 1'b0;
      go     = 1'b0;
      new_x  = '0;
      new_y  = '0;
      repeat (3) @(negedge clock);
      check("rst_ready", 32'(ready), 1);
      check("rst_plot",  32'(plot), 0);
      check("rst_done",  32'(done), 0);
      check("rst_x",     32'(x), 0);
      check("rst_y",     32'(y), 0);
      resetn = 1'b1;
      repeat (2) @(negedge clock);

      // Table of directed lines, origin chained from one to the next
      for (int i = 0; i < 8; i++) begin
         ex = clip_x(tbl[i].nx);
         ey = clip_y(tbl[i].ny);
         model_line(ox, oy, ex, ey);
         start_line(tbl[i].nx, tbl[i].ny);
         collect(0, n, lx, ly);
         check("pixel_count", n, tbl[i].exp_n);
         check("last_x", lx, tbl[i].lx);
         check("last_y", ly, tbl[i].ly);
         if (i == 3) begin
            // Steep line: y advances every pixel, x follows the tie rule e2 == dy
            for (int k = 0; k < 9; k++) begin
               check("steep_x_seq", (k < x_log.size()) ? x_log[k] : -1, x_hand[k]);
               check("steep_y_seq", (k < y_log.size()) ? y_log[k] : -1, k);
            end
         end
         ox = ex;
         oy = ey;
      end

      // go toggled during a 100-pixel line: line unchanged, no second line
      model_line(ox, oy, 99, 0);
      start_line(99, 0);
      collect(30, n, lx, ly);
      check("toggle_count", n, 100);
      check("toggle_last_x", lx, 99);
      check("toggle_last_y", ly, 0);
      ox = 99;
      oy = 0;
      quiet = 0;
      repeat (20) begin
         @(negedge clock);
         if (plot || !ready) quiet++;
      end
      check("no_second_line", quiet, 0);
      go = 1'b0;
      repeat (4) @(negedge clock);

      // Reset asserted mid-line aborts at once and clears the origin
      start_line(300, 0);
      repeat (20) @(negedge clock);
      check("abort_plot_before", 32'(plot), 1);
      #2 resetn = 1'b0;
      #1;
      check("abort_plot", 32'(plot), 0);
      check("abort_ready", 32'(ready), 1);
      check("abort_done", 32'(done), 0);
      check("abort_x", 32'(x), 0);
      check("abort_y", 32'(y), 0);
      @(negedge clock);
      resetn = 1'b1;
      ox = 0;
      oy = 0;
      repeat (2) @(negedge clock);
      model_line(0, 0, 3, 0);
      start_line(3, 0);
      collect(0, n, lx, ly);
      check("post_abort_count", n, 4);
      check("post_abort_last_x", lx, 3);
      ox = 3;

      // go held high through reset release yields a start
      @(negedge clock);
      resetn = 1'b0;
      go     = 1'b1;
      new_x  = 9'd5;
      new_y  = 8'd5;
      repeat (3) @(negedge clock);
      check("held_go_rst_ready", 32'(ready), 1);
      resetn = 1'b1;
      cyc = 0;
      while (ready && cyc < 8) begin
         @(negedge clock);
         cyc++;
      end
      check("held_go_start_latency", cyc, 3);
      model_line(0, 0, 5, 5);
      collect(0, n, lx, ly);
      check("held_go_count", n, 6);
      check("held_go_last_x", lx, 5);
      check("held_go_last_y", ly, 5);
      go = 1'b0;
      repeat (4) @(negedge clock);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
